// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - command encoding and handshake states for spi_ram_ctrl
package spi_ram_pkg;

  localparam int CMD_W = 2;

  typedef enum logic [CMD_W-1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  // IDLE: no read data outstanding; HOLD: dout waiting for tx_ack
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hs_state_e;

endpackage

// File: rtl/spi_ram_array.sv
// rtl/spi_ram_array.sv - single-port storage with registered read data
module spi_ram_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_SIZE-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Contents are intentionally not reset; the caller only presents in-range addresses
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port and read register; r_rdata holds its value when i_re is low
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_ctrl.sv
// rtl/spi_ram_ctrl.sv - command-decoded RAM front end for the SPI slave
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int AUTO_INC   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH+CMD_W-1:0] din,
  input  logic                        rx_valid,
  input  logic                        tx_ack,
  output logic [DATA_WIDTH-1:0]       dout,
  output logic                        tx_valid,
  output logic                        err_ovr
);

  localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(MEM_DEPTH - 1);
  localparam logic [ADDR_SIZE:0]   DEPTH_EXT = (ADDR_SIZE + 1)'(MEM_DEPTH);

  // Wrap at MEM_DEPTH; out-of-range pointers simply count upward
  function automatic logic [ADDR_SIZE-1:0] ptr_next(input logic [ADDR_SIZE-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  hs_state_e             r_state;
  hs_state_e             w_state_next;
  logic [ADDR_SIZE-1:0]  r_wr_ptr;
  logic [ADDR_SIZE-1:0]  r_rd_ptr;
  logic                  r_err_ovr;
  logic                  r_dout_zero;

  cmd_e                  w_cmd;
  logic [DATA_WIDTH-1:0] w_payload;
  logic                  w_rd_req;
  logic                  w_wr_req;
  logic                  w_rd_accept;
  logic                  w_overrun;
  logic                  w_wr_inrange;
  logic                  w_rd_inrange;
  logic                  w_mem_we;
  logic                  w_mem_re;
  logic [ADDR_SIZE-1:0]  w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_cmd        = cmd_e'(din[DATA_WIDTH+CMD_W-1:DATA_WIDTH]);
  assign w_payload    = din[DATA_WIDTH-1:0];
  assign w_rd_req     = rx_valid && (w_cmd == RD_DATA);
  assign w_wr_req     = rx_valid && (w_cmd == WR_DATA);
  assign w_wr_inrange = ({1'b0, r_wr_ptr} < DEPTH_EXT);
  assign w_rd_inrange = ({1'b0, r_rd_ptr} < DEPTH_EXT);

  // A single port is enough: only one command arrives per cycle
  assign w_mem_we   = w_wr_req && w_wr_inrange;
  assign w_mem_re   = w_rd_accept && w_rd_inrange;
  assign w_mem_addr = w_rd_req ? r_rd_ptr : r_wr_ptr;

  spi_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE),
    .MEM_DEPTH  (MEM_DEPTH)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_payload),
    .o_rdata (w_mem_rdata)
  );

  // Handshake next state: accept a read unless dout is still unacknowledged
  always_comb begin
    w_state_next = r_state;
    w_rd_accept  = 1'b0;
    w_overrun    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_req) begin
          w_rd_accept  = 1'b1;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_rd_req) begin
          if (tx_ack) begin
            w_rd_accept = 1'b1;
          end else begin
            w_overrun = 1'b1;
          end
        end else if (tx_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Handshake state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Pointers, sticky overrun flag and the dout zero-mask (reset / out-of-range read)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_err_ovr   <= 1'b0;
      r_dout_zero <= 1'b1;
    end else begin
      if (w_overrun) begin
        r_err_ovr <= 1'b1;
      end
      if (w_rd_accept) begin
        r_dout_zero <= !w_rd_inrange;
      end
      if (rx_valid) begin
        case (w_cmd)
          WR_ADDR: r_wr_ptr <= w_payload[ADDR_SIZE-1:0];
          WR_DATA: if (AUTO_INC != 0) r_wr_ptr <= ptr_next(r_wr_ptr);
          RD_ADDR: r_rd_ptr <= w_payload[ADDR_SIZE-1:0];
          RD_DATA: if (w_rd_accept && (AUTO_INC != 0)) r_rd_ptr <= ptr_next(r_rd_ptr);
          default: ;
        endcase
      end
    end
  end

  assign dout     = r_dout_zero ? '0 : w_mem_rdata;
  assign tx_valid = (r_state == ST_HOLD);
  assign err_ovr  = r_err_ovr;

endmodule

// File: doc/spi_ram_ctrl.md
# spi_ram_ctrl

Parametrised single-port RAM with a command-decoded front end, sitting behind the SPI slave's deserialiser. It accepts `{cmd, payload}` words from the SPI receive path, keeps independent write and read address pointers with optional auto-increment for burst transfers, and returns read data on a held `tx_valid` / `tx_ack` handshake for the SPI transmit path. It succeeds the fixed 256×8 RAM with generic width and depth, burst mode, out-of-range handling and overrun detection.

## Interface
- `DATA_WIDTH`, 8, payload and memory word width; also the address-payload width, so it must be ≥ `ADDR_SIZE`.
- `ADDR_SIZE`, 8, address pointer width.
- `MEM_DEPTH`, 256, number of words; must satisfy `MEM_DEPTH` ≤ 2^`ADDR_SIZE`.
- `AUTO_INC`, 1, when 1 each data command post-increments its pointer.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  `DATA_WIDTH`+2  `[DATA_WIDTH+1:DATA_WIDTH]` is the command, `[DATA_WIDTH-1:0]` is the payload.
- `rx_valid`  in  1  `din` is valid this cycle; one command per cycle.
- `tx_ack`  in  1  consumer has taken `dout`.
- `dout`  out  `DATA_WIDTH`  read data.
- `tx_valid`  out  1  `dout` is valid; held until acknowledged.
- `err_ovr`  out  1  sticky overrun flag.

## Operation
- Commands, sampled when `rx_valid`=1:
  - 00 `WR_ADDR`: `wr_ptr` ← `payload[ADDR_SIZE-1:0]`.
  - 01 `WR_DATA`: `mem[wr_ptr]` ← payload; if `AUTO_INC`, `wr_ptr` ← next(`wr_ptr`).
  - 10 `RD_ADDR`: `rd_ptr` ← `payload[ADDR_SIZE-1:0]`.
  - 11 `RD_DATA`: payload is ignored; `dout` ← `mem[rd_ptr]`; `tx_valid` ← 1; if `AUTO_INC`, `rd_ptr` ← next(`rd_ptr`).
- next(p) = 0 if p = `MEM_DEPTH`-1, otherwise p+1. Wrap is at `MEM_DEPTH`, not at 2^`ADDR_SIZE`.
- Out-of-range pointer (≥ `MEM_DEPTH`), reachable only via an address command:
  - `WR_DATA` does not write memory and the pointer still advances via next() (p+1, no wrap unless p = `MEM_DEPTH`-1).
  - `RD_DATA` returns 0 with `tx_valid`=1.
- Handshake states are IDLE (`tx_valid`=0) and HOLD (`tx_valid`=1).
  - IDLE → HOLD on `RD_DATA`.
  - HOLD → IDLE on `tx_ack` with no `RD_DATA` in the same cycle.
  - HOLD → HOLD with new data on `tx_ack` and `RD_DATA` together.
- Overrun: `RD_DATA` in HOLD without `tx_ack`:
  - command dropped: `dout`, `rd_ptr` unchanged;
  - `err_ovr` ← 1, cleared only by `rst`.
- `tx_ack` in IDLE is ignored.
- `rx_valid`=0: no state change, except `tx_ack` handling.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: `dout`=0, `tx_valid`=0, `err_ovr`=0, `wr_ptr`=0, `rd_ptr`=0, state IDLE.
- `rst` has priority over every command in the same cycle.
- `rst` mid-burst resets the pointers and drops any pending `tx_valid`; memory keeps its contents.
- Write commits at the edge sampling `WR_DATA`.
- Read latency is 1: `dout`/`tx_valid` are updated at the edge that samples `RD_DATA`.
- `WR_DATA` to address A followed by `RD_DATA` of A in the next cycle returns the new data (no bypass needed).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `spi_ram_pkg`: `cmd_e` enum (`WR_ADDR`=2'b00, `WR_DATA`=2'b01, `RD_ADDR`=2'b10, `RD_DATA`=2'b11) and the `CMD_W`=2 constant.
- Sub-module `spi_ram_array`: parametrised single-port storage (`we`, `addr`, `wdata`, `rdata` registered), so it can later be swapped for a vendor macro.
- `spi_ram_ctrl` holds the decode, the pointers, the handshake FSM and the overrun flag.

## Test plan
- Reset check: drive `rst`=1 for 1 cycle → `dout`=0, `tx_valid`=0, `err_ovr`=0.
- Single write/read: `WR_ADDR` 0x05, `WR_DATA` 0xA5, `RD_ADDR` 0x05, `RD_DATA` → next cycle `dout`=0xA5, `tx_valid`=1; `tx_ack` → `tx_valid`=0.
- Burst with wrap (`MEM_DEPTH`=16, `AUTO_INC`=1):
  - `WR_ADDR` 14, then write 0x11, 0x22, 0x33;
  - `RD_ADDR` 14, then 3× `RD_DATA` each acked → 0x11, 0x22, 0x33, and address 0 holds 0x33.
- Overrun: `RD_DATA` twice with no `tx_ack` → `dout` keeps the first value and `err_ovr`=1 until `rst`. A third `RD_DATA` issued together with `tx_ack` → `dout` updates and `tx_valid` stays 1.
- Out of range (`MEM_DEPTH`=200): `WR_ADDR` 210, `WR_DATA` 0x7E, `RD_ADDR` 210, `RD_DATA` → `dout`=0; address 199 is unchanged.
- Reset mid-burst: assert `rst` while `tx_valid`=1 → `tx_valid`=0. Data written before the reset reads back intact after it.
